// File: rtl/lane_xyz_gather_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_xyz_gather_if
// Description : Bundle of the flattened per-lane x/y/z inputs, the one-hot
//               lane grant, and the packed {index,x,y,z} record output of
//               lane_xyz_gather. The out_parity member exists only when
//               LANE_XYZ_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_xyz_gather_if #(
  parameter int NUM_LANES = 2,
  parameter int W         = 8
);
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]   lane_valid;
  logic [NUM_LANES*W-1:0] lane_x;
  logic [NUM_LANES*W-1:0] lane_y;
  logic [NUM_LANES*W-1:0] lane_z;
  logic [NUM_LANES-1:0]   lane_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [IW-1:0]          out_index;
  logic [W-1:0]           out_x;
  logic [W-1:0]           out_y;
  logic [W-1:0]           out_z;
  logic [15:0]            out_count;
`ifdef LANE_XYZ_PARITY_EN
  logic                   out_parity;
`endif

  // Gather block side: consumes lanes, produces the packed record
  modport slave (
    input  lane_valid, lane_x, lane_y, lane_z, out_ready,
    output lane_ready, out_valid, out_index, out_x, out_y, out_z, out_count
`ifdef LANE_XYZ_PARITY_EN
    , output out_parity
`endif
  );

  // Environment side: drives lanes and the consumer ready
  modport master (
    output lane_valid, lane_x, lane_y, lane_z, out_ready,
    input  lane_ready, out_valid, out_index, out_x, out_y, out_z, out_count
`ifdef LANE_XYZ_PARITY_EN
    , input out_parity
`endif
  );
endinterface
`default_nettype wire

// File: rtl/lane_xyz_gather.sv
`default_nettype none
// ============================================================================
// Module      : lane_xyz_gather
// Description : Round-robin gather of NUM_LANES flattened x/y/z lanes into a
//               single time-multiplexed {index,x,y,z} record stream with one
//               registered valid/ready output stage and a saturating
//               accepted-record counter.
//               Optional macro LANE_XYZ_PARITY_EN adds a registered even
//               parity bit over {index,x,y,z}.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_xyz_gather #(
  parameter int NUM_LANES = 2,
  parameter int W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  lane_xyz_gather_if.slave bus
);
  localparam int             IW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IW:0]    LANES_EXT = (IW+1)'(NUM_LANES);
  localparam logic [IW-1:0]  LAST_LANE = IW'(NUM_LANES - 1);
  localparam logic [15:0]    COUNT_MAX = 16'hFFFF;

  // Output stage occupancy; out_valid is simply "stage is FULL"
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  index_q, index_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   z_q, z_d;
  logic [15:0]    count_q, count_d;
`ifdef LANE_XYZ_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic                 out_valid;
  logic                 load_ok;
  logic                 handshake;
  logic                 grant_valid;
  logic [IW-1:0]        grant_idx;
  logic [NUM_LANES-1:0] grant_oh;
  logic [IW:0]          cand;
  logic [W-1:0]         sel_x, sel_y, sel_z;

  assign out_valid = (state_q == ST_FULL);
  assign load_ok   = !out_valid || bus.out_ready;
  assign handshake = out_valid && bus.out_ready;

  // Round-robin scan from rr_ptr; first valid lane wins, suppressed under reset or stall
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= LANES_EXT) begin
        cand = cand - LANES_EXT;
      end
      if (!grant_valid && bus.lane_valid[cand[IW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
    if (rst || !load_ok) begin
      grant_valid = 1'b0;
      grant_idx   = '0;
    end
    if (grant_valid) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Field mux for the granted lane
  always_comb begin
    sel_x = bus.lane_x[int'(grant_idx)*W +: W];
    sel_y = bus.lane_y[int'(grant_idx)*W +: W];
    sel_z = bus.lane_z[int'(grant_idx)*W +: W];
  end

  // Next state of output stage, pointer and counter
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    index_d  = index_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    count_d  = count_q;
`ifdef LANE_XYZ_PARITY_EN
    parity_d = parity_q;
`endif
    if (grant_valid) begin
      // A load during a handshake replaces the drained record with no bubble
      state_d  = ST_FULL;
      index_d  = grant_idx;
      x_d      = sel_x;
      y_d      = sel_y;
      z_d      = sel_z;
      rr_ptr_d = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
`ifdef LANE_XYZ_PARITY_EN
      parity_d = ^{grant_idx, sel_x, sel_y, sel_z};
`endif
    end else if (handshake) begin
      state_d = ST_EMPTY;
    end
    if (handshake && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  // State registers with synchronous reset; a pending record is dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      index_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      count_q  <= '0;
`ifdef LANE_XYZ_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      index_q  <= index_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      count_q  <= count_d;
`ifdef LANE_XYZ_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.lane_ready = grant_oh;
  assign bus.out_valid  = out_valid;
  assign bus.out_index  = index_q;
  assign bus.out_x      = x_q;
  assign bus.out_y      = y_q;
  assign bus.out_z      = z_q;
  assign bus.out_count  = count_q;
`ifdef LANE_XYZ_PARITY_EN
  assign bus.out_parity = parity_q;
`endif

endmodule
`default_nettype wire
